bg_pixel_fetcher: RTL and testbench

- Memory-side responder for the VGA background path.
- Streams background pixels for the current frame from SDRAM into a small prefetch FIFO.
- Supplies one 24-bit RGB pixel per consumed display pixel.
- Outputs drive the image-merge block's sdram_R/G/B inputs. The display-timing block consumes pixels in raster order.

---
 rtl/bg_fetch_pkg.sv | 24 ++
 rtl/bg_pixel_fetcher_if.sv | 25 ++
 rtl/bg_fifo.sv | 64 ++++++
 rtl/bg_pixel_fetcher.sv | 181 ++++++++++++++++++
 tb/tb_bg_pixel_fetcher.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bg_fetch_pkg.sv
// bg_fetch_pkg: shared types and constants for the background pixel fetcher.
//   bg_state_e              fetch state (IDLE, STREAM, DONE, FLUSH)
//   pixel_t                 packed {r,g,b}, 8 bits each
//   UNDERFLOW_COLOR_DEFAULT colour emitted on a pop from an empty FIFO
//   SKIP_W                  width of the drop-after-underflow counter
package bg_fetch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DONE   = 2'd2,
      ST_FLUSH  = 2'd3
   } bg_state_e;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } pixel_t;

   localparam logic [23:0] UNDERFLOW_COLOR_DEFAULT = 24'hFF00FF;
   localparam int          SKIP_W                  = 16;

endpackage

// File: rtl/bg_pixel_fetcher_if.sv
// bg_pixel_fetcher_if: SDRAM read-request / read-return bus.
// Handshake: a request transfers on a cycle where rd_req && rd_ack; rd_req and
// rd_addr hold stable until that cycle. Returned words arrive in request order,
// one per accepted request, each flagged by a single-cycle rd_valid with rd_data.
//   master: fetcher (drives rd_req, rd_addr)
//   slave : SDRAM controller (drives rd_ack, rd_valid, rd_data)
interface bg_pixel_fetcher_if #(
   parameter int ADDR_W = 20
);
   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_ack;
   logic              rd_valid;
   logic [23:0]       rd_data;

   modport master (
      output rd_req, rd_addr,
      input  rd_ack, rd_valid, rd_data
   );

   modport slave (
      input  rd_req, rd_addr,
      output rd_ack, rd_valid, rd_data
   );
endinterface

// File: rtl/bg_fifo.sv
// bg_fifo: synchronous show-ahead FIFO (head is the oldest entry, valid when
// not empty). Power-of-two DEPTH so the pointers wrap naturally.
//   clk, rst   clock, async active-high reset
//   clear      synchronous empty (drops all entries)
//   push       write push_data (ignored when full)
//   pop        drop head (ignored when empty)
//   head       oldest entry
//   count      number of entries, full, empty
module bg_fifo #(
   parameter int WIDTH = 24,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      cnt_q;
   logic             do_push;
   logic             do_pop;

   assign full    = (cnt_q == (AW+1)'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem_q[rd_ptr];
   assign count   = cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Storage needs no reset: entries are only read once counted valid.
   always_ff @(posedge clk) begin
      if (do_push && !clear) mem_q[wr_ptr] <= push_data;
   end
endmodule

// File: rtl/bg_pixel_fetcher.sv
// bg_pixel_fetcher: streams a frame of background pixels from SDRAM into a
// prefetch FIFO and hands one RGB pixel per visible display pixel to the
// image-merge block.
//   clk, rst        clock, async active-high reset
//   frame_start     pulse at start of vertical blank; restarts the fetch
//   pix_en, active  pixel strobe and visible-area flag; together they pop
//   mem             SDRAM read bus (master side)
//   sdram_R/G/B     current pixel, pix_valid marks a cycle it was updated
//   underflow       sticky, set by a pop from an empty FIFO
//   underflow_count underflow pops (saturating), needs BG_FETCH_STATS_EN
//   dbg_state       current fetch state
// Optional feature macro: BG_FETCH_STATS_EN enables underflow_count.
module bg_pixel_fetcher
   import bg_fetch_pkg::*;
#(
   parameter int                ADDR_W          = 20,
   parameter int                FIFO_DEPTH      = 16,
   parameter int                MAX_OUTSTANDING = 8,
   parameter int                FRAME_PIXELS    = 307200,
   parameter logic [ADDR_W-1:0] BASE_ADDR       = '0,
   parameter logic [23:0]       UNDERFLOW_COLOR = UNDERFLOW_COLOR_DEFAULT
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      frame_start,
   input  logic                      pix_en,
   input  logic                      active,
   bg_pixel_fetcher_if.master        mem,
   output logic [7:0]                sdram_R,
   output logic [7:0]                sdram_G,
   output logic [7:0]                sdram_B,
   output logic                      pix_valid,
   output logic                      underflow,
   output logic [15:0]               underflow_count,
   output bg_state_e                 dbg_state
);
   localparam int FAW     = $clog2(FIFO_DEPTH);
   localparam int OUT_W   = $clog2(MAX_OUTSTANDING + 1);
   localparam int FETCH_W = $clog2(FRAME_PIXELS + 1);
   localparam int SUM_W   = FAW + 2;

   bg_state_e          state;
   logic [FETCH_W-1:0] fetched;
   logic [OUT_W-1:0]   outstanding;
   logic [SKIP_W-1:0]  skip_cnt;
   pixel_t             pix_q;

   logic [FAW:0]       fifo_count;
   logic               fifo_full;
   logic               fifo_empty;
   logic [23:0]        fifo_head;

   logic pop_req, uf_pop, fifo_pop;
   logic ret_ok, push, drop_skip;
   logic credit_ok, accept;

   // frame_start takes priority over a pop and over a same-cycle return.
   assign pop_req  = pix_en && active && (state != ST_FLUSH) && !frame_start;
   assign uf_pop   = pop_req && fifo_empty;
   assign fifo_pop = pop_req && !fifo_empty;

   // Each underflow pop owes one dropped return to keep raster alignment; a
   // word arriving on the same cycle as an underflow pop settles that debt.
   assign ret_ok    = mem.rd_valid && (state != ST_FLUSH) && !frame_start;
   assign push      = ret_ok && (skip_cnt == '0) && !uf_pop;
   assign drop_skip = ret_ok && ((skip_cnt != '0) || uf_pop);

   // Buffered plus in-flight words never exceed the FIFO, so a push is never
   // refused. Without an accept this sum only falls, so rd_req never withdraws.
   assign credit_ok = (SUM_W'(fifo_count) + SUM_W'(outstanding)) < SUM_W'(FIFO_DEPTH);
   assign mem.rd_req = (state == ST_STREAM) && credit_ok
                       && (outstanding < OUT_W'(MAX_OUTSTANDING))
                       && (fetched < FETCH_W'(FRAME_PIXELS));
   assign accept = mem.rd_req && mem.rd_ack;

   bg_fifo #(
      .WIDTH (24),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .clear     (state == ST_FLUSH),
      .push      (push),
      .push_data (mem.rd_data),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         mem.rd_addr <= BASE_ADDR;
         fetched     <= '0;
         outstanding <= '0;
         skip_cnt    <= '0;
         pix_q       <= '0;
         pix_valid   <= 1'b0;
         underflow   <= 1'b0;
      end else begin
         case ({accept, mem.rd_valid})
            2'b10:   outstanding <= outstanding + 1'b1;
            2'b01:   outstanding <= outstanding - 1'b1;
            default: outstanding <= outstanding;
         endcase

         case (state)
            ST_IDLE: begin
               if (frame_start) begin
                  state       <= ST_STREAM;
                  mem.rd_addr <= BASE_ADDR;
                  fetched     <= '0;
               end
            end
            ST_STREAM: begin
               if (frame_start) begin
                  state       <= ST_FLUSH;
                  mem.rd_addr <= BASE_ADDR;
                  fetched     <= '0;
               end else begin
                  if (accept) begin
                     mem.rd_addr <= mem.rd_addr + 1'b1;
                     fetched     <= fetched + 1'b1;
                  end
                  if (fetched == FETCH_W'(FRAME_PIXELS)) state <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (frame_start) begin
                  state       <= ST_FLUSH;
                  mem.rd_addr <= BASE_ADDR;
                  fetched     <= '0;
               end
            end
            ST_FLUSH: begin
               // Always at least one cycle here, so the FIFO clear lands.
               if (outstanding == '0) state <= ST_STREAM;
            end
            default: state <= ST_IDLE;
         endcase

         if (frame_start) begin
            skip_cnt <= '0;
         end else begin
            case ({uf_pop, drop_skip})
               2'b10: if (skip_cnt != '1) skip_cnt <= skip_cnt + 1'b1;
               2'b01: skip_cnt <= skip_cnt - 1'b1;
               default: skip_cnt <= skip_cnt;
            endcase
         end

         if (uf_pop)        pix_q <= pixel_t'(UNDERFLOW_COLOR);
         else if (fifo_pop) pix_q <= pixel_t'(fifo_head);
         pix_valid <= uf_pop || fifo_pop;

         if (frame_start)  underflow <= 1'b0;
         else if (uf_pop)  underflow <= 1'b1;
      end
   end

`ifdef BG_FETCH_STATS_EN
   logic [15:0] uf_cnt_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                             uf_cnt_q <= '0;
      else if (frame_start)                uf_cnt_q <= '0;
      else if (uf_pop && uf_cnt_q != '1)   uf_cnt_q <= uf_cnt_q + 1'b1;
   end
   assign underflow_count = uf_cnt_q;
`else
   assign underflow_count = '0;
`endif

   assign sdram_R   = pix_q.r;
   assign sdram_G   = pix_q.g;
   assign sdram_B   = pix_q.b;
   assign dbg_state = state;

   a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && fifo_full));
endmodule

// File: tb/tb_bg_pixel_fetcher.sv
// tb_bg_pixel_fetcher: directed bench for bg_pixel_fetcher (FRAME_PIXELS=32).
// A behavioural SDRAM controller acknowledges requests (optionally capped) and
// returns data = address two cycles after acceptance.
module tb_bg_pixel_fetcher;
   import bg_fetch_pkg::*;

   localparam int ADDR_W = 20;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        frame_start = 1'b0;
   logic        pix_en = 1'b0;
   logic        active = 1'b0;
   logic [7:0]  sdram_R, sdram_G, sdram_B;
   logic        pix_valid, underflow;
   logic [15:0] underflow_count;
   bg_state_e   dbg_state;

   int checks = 0;
   int errors = 0;

   bg_pixel_fetcher_if #(.ADDR_W(ADDR_W)) mem ();

   bg_pixel_fetcher #(
      .ADDR_W          (ADDR_W),
      .FIFO_DEPTH      (16),
      .MAX_OUTSTANDING (8),
      .FRAME_PIXELS    (32),
      .BASE_ADDR       ('0),
      .UNDERFLOW_COLOR (24'hFF00FF)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .frame_start     (frame_start),
      .pix_en          (pix_en),
      .active          (active),
      .mem             (mem),
      .sdram_R         (sdram_R),
      .sdram_G         (sdram_G),
      .sdram_B         (sdram_B),
      .pix_valid       (pix_valid),
      .underflow       (underflow),
      .underflow_count (underflow_count),
      .dbg_state       (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- SDRAM controller model ----------------
   logic              ack_en = 1'b1;
   logic              ret_en = 1'b1;
   int                acc_limit = 1 << 30;
   logic [ADDR_W-1:0] acc_q[$];
   logic [ADDR_W-1:0] pend_addr[$];
   int                pend_due[$];
   int                slv_cyc = 0;
   logic [23:0]       exp_q[$];

   always @(negedge clk) begin
      slv_cyc++;
      if (rst) begin
         pend_addr.delete();
         pend_due.delete();
         mem.rd_ack   = 1'b0;
         mem.rd_valid = 1'b0;
         mem.rd_data  = '0;
      end else begin
         if (ret_en && pend_due.size() > 0 && pend_due[0] <= slv_cyc) begin
            mem.rd_valid = 1'b1;
            mem.rd_data  = 24'(pend_addr.pop_front());
            void'(pend_due.pop_front());
         end else begin
            mem.rd_valid = 1'b0;
         end
         mem.rd_ack = ack_en && (acc_q.size() < acc_limit);
         if (mem.rd_req && mem.rd_ack) begin
            acc_q.push_back(mem.rd_addr);
            pend_addr.push_back(mem.rd_addr);
            pend_due.push_back(slv_cyc + 2);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset;
      rst = 1'b1;
      frame_start = 1'b0;
      pix_en = 1'b0;
      active = 1'b0;
      ack_en = 1'b1;
      ret_en = 1'b1;
      acc_limit = 1 << 30;
      tick(2);
      acc_q.delete();
      rst = 1'b0;
      tick(1);
   endtask

   task automatic pulse_frame_start;
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
   endtask

   task automatic pop_once(output logic [23:0] px, output logic pv);
      pix_en = 1'b1;
      active = 1'b1;
      @(negedge clk);
      pix_en = 1'b0;
      active = 1'b0;
      px = {sdram_R, sdram_G, sdram_B};
      pv = pix_valid;
   endtask

   task automatic check_acc_seq(input string name, input int n);
      int bad;
      bad = (acc_q.size() != n) ? 1 : 0;
      for (int i = 0; i < acc_q.size() && i < n; i++)
         if (acc_q[i] !== ADDR_W'(i)) bad = 1;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL %s got %0d requests (last %0h) exp %0d requests 0..%0d", name,
                  acc_q.size(), (acc_q.size() > 0) ? acc_q[acc_q.size()-1] : '0, n, n-1);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset;
      rst = 1'b1;
      tick(2);
      checks++; if (mem.rd_req !== 1'b0) begin errors++; $display("FAIL reset_rd_req got %b exp 0", mem.rd_req); end
      checks++; if (mem.rd_addr !== '0) begin errors++; $display("FAIL reset_rd_addr got %0h exp 0", mem.rd_addr); end
      checks++; if ({sdram_R, sdram_G, sdram_B} !== 24'h0) begin errors++; $display("FAIL reset_pixel got %h exp 000000", {sdram_R, sdram_G, sdram_B}); end
      checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL reset_pix_valid got %b exp 0", pix_valid); end
      checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow got %b exp 0", underflow); end
      checks++; if (underflow_count !== 16'h0) begin errors++; $display("FAIL reset_uf_count got %h exp 0", underflow_count); end
      checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d exp %0d", dbg_state, ST_IDLE); end
      do_reset();
      tick(3);
      checks++; if (mem.rd_req !== 1'b0) begin errors++; $display("FAIL idle_no_req got %b exp 0", mem.rd_req); end
   endtask

   task automatic test_fill_and_ack_stall;
      logic [23:0] px;
      logic        pv;
      do_reset();
      pulse_frame_start();
      tick(40);
      check_acc_seq("fill_requests", 16);
      checks++; if (mem.rd_req !== 1'b0 || mem.rd_addr !== 20'd16) begin errors++; $display("FAIL fill_stall got req %b addr %0h exp req 0 addr 10", mem.rd_req, mem.rd_addr); end
      for (int i = 0; i < 2; i++) begin
         pop_once(px, pv);
         checks++; if (px !== 24'(i) || pv !== 1'b1) begin errors++; $display("FAIL fill_pop%0d got %h/%b exp %h/1", i, px, pv, 24'(i)); end
      end
      tick(1);
      checks++; if (pix_valid !== 1'b0 || {sdram_R, sdram_G, sdram_B} !== 24'h000001) begin errors++; $display("FAIL hold_output got %h/%b exp 000001/0", {sdram_R, sdram_G, sdram_B}, pix_valid); end
      tick(6);
      ack_en = 1'b0;
      tick(2);
      for (int i = 2; i < 5; i++) begin
         pop_once(px, pv);
         checks++; if (px !== 24'(i)) begin errors++; $display("FAIL stall_pop%0d got %h exp %h", i, px, 24'(i)); end
      end
      for (int i = 0; i < 5; i++) begin
         tick(1);
         checks++; if (mem.rd_req !== 1'b1 || mem.rd_addr !== 20'd18) begin errors++; $display("FAIL ack_stall_cycle%0d got req %b addr %0h exp req 1 addr 12", i, mem.rd_req, mem.rd_addr); end
      end
      ack_en = 1'b1;
      tick(10);
      check_acc_seq("after_stall_requests", 21);
   endtask

   task automatic test_underflow;
      logic [23:0] px;
      logic        pv;
      do_reset();
      ret_en = 1'b0;
      tick(1);
      pulse_frame_start();
      tick(20);
      check_acc_seq("outstanding_cap", 8);
      for (int i = 0; i < 3; i++) begin
         pop_once(px, pv);
         checks++; if (px !== 24'hFF00FF || pv !== 1'b1) begin errors++; $display("FAIL uf_pop%0d got %h/%b exp ff00ff/1", i, px, pv); end
      end
      checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_sticky got %b exp 1", underflow); end
`ifdef BG_FETCH_STATS_EN
      checks++; if (underflow_count !== 16'd3) begin errors++; $display("FAIL uf_count got %0d exp 3", underflow_count); end
`else
      checks++; if (underflow_count !== 16'd0) begin errors++; $display("FAIL uf_count got %0d exp 0", underflow_count); end
`endif
      ret_en = 1'b1;
      tick(30);
      pop_once(px, pv);
      checks++; if (px !== 24'h000003 || pv !== 1'b1) begin errors++; $display("FAIL uf_realign got %h/%b exp 000003/1", px, pv); end
      checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_still_sticky got %b exp 1", underflow); end
   endtask

   task automatic test_flush;
      logic [23:0] px;
      logic        pv;
      do_reset();
      ret_en = 1'b0;
      acc_limit = 5;
      tick(1);
      pulse_frame_start();
      tick(10);
      check_acc_seq("flush_pre_requests", 5);
      pop_once(px, pv);
      checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL flush_pre_uf got %b exp 1", underflow); end
      pulse_frame_start();
      for (int i = 0; i < 4; i++) begin
         checks++; if (dbg_state !== ST_FLUSH || mem.rd_req !== 1'b0) begin errors++; $display("FAIL flush_hold%0d got state %0d req %b exp state %0d req 0", i, dbg_state, mem.rd_req, ST_FLUSH); end
         tick(1);
      end
      checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL flush_uf_clear got %b exp 0", underflow); end
      acc_limit = 1000;
      ret_en = 1'b1;
      tick(30);
      checks++; if (acc_q.size() < 6 || acc_q[5] !== 20'd0) begin errors++; $display("FAIL flush_restart_addr got size %0d exp first new addr 0", acc_q.size()); end
      pop_once(px, pv);
      checks++; if (px !== 24'h000000 || pv !== 1'b1) begin errors++; $display("FAIL flush_first_pixel got %h/%b exp 000000/1", px, pv); end
   endtask

   task automatic test_frame_done;
      logic [23:0] px;
      logic        pv;
      do_reset();
      pulse_frame_start();
      tick(40);
      for (int i = 0; i < 20; i++) exp_q.push_back(24'(i));
      for (int i = 0; i < 20; i++) begin
         logic [23:0] e;
         e = exp_q.pop_front();
         pop_once(px, pv);
         checks++; if (px !== e) begin errors++; $display("FAIL done_pop%0d got %h exp %h", i, px, e); end
         tick(1);
      end
      tick(20);
      check_acc_seq("frame_requests", 32);
      checks++; if (dbg_state !== ST_DONE || mem.rd_req !== 1'b0) begin errors++; $display("FAIL done_state got state %0d req %b exp state %0d req 0", dbg_state, mem.rd_req, ST_DONE); end
      tick(5);
      checks++; if (mem.rd_req !== 1'b0 || acc_q.size() != 32) begin errors++; $display("FAIL done_quiet got req %b count %0d exp req 0 count 32", mem.rd_req, acc_q.size()); end
      pulse_frame_start();
      tick(20);
      checks++; if (acc_q.size() < 33 || acc_q[32] !== 20'd0 || dbg_state !== ST_STREAM) begin errors++; $display("FAIL done_restart got count %0d state %0d exp next addr 0 state %0d", acc_q.size(), dbg_state, ST_STREAM); end
   endtask

   task automatic test_reset_mid_burst;
      logic [23:0] px;
      logic        pv;
      pop_once(px, pv);
      #2 rst = 1'b1;
      #1;
      checks++; if (mem.rd_req !== 1'b0 || mem.rd_addr !== '0 || dbg_state !== ST_IDLE) begin errors++; $display("FAIL midrst_ctrl got req %b addr %0h state %0d exp 0 0 %0d", mem.rd_req, mem.rd_addr, dbg_state, ST_IDLE); end
      checks++; if (pix_valid !== 1'b0 || {sdram_R, sdram_G, sdram_B} !== 24'h0) begin errors++; $display("FAIL midrst_pixel got %h/%b exp 000000/0", {sdram_R, sdram_G, sdram_B}, pix_valid); end
      tick(2);
      do_reset();
   endtask

   task automatic test_stats;
      do_reset();
      pix_en = 1'b1;
      active = 1'b1;
`ifdef BG_FETCH_STATS_EN
      tick(70000);
`else
      tick(10);
`endif
      pix_en = 1'b0;
      active = 1'b0;
      tick(1);
      checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL stats_underflow got %b exp 1", underflow); end
`ifdef BG_FETCH_STATS_EN
      checks++; if (underflow_count !== 16'hFFFF) begin errors++; $display("FAIL stats_saturate got %h exp ffff", underflow_count); end
`else
      checks++; if (underflow_count !== 16'h0) begin errors++; $display("FAIL stats_disabled got %h exp 0000", underflow_count); end
`endif
      pulse_frame_start();
      checks++; if (underflow !== 1'b0 || underflow_count !== 16'h0) begin errors++; $display("FAIL stats_clear got %b/%h exp 0/0000", underflow, underflow_count); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_fill_and_ack_stall();
      test_underflow();
      test_flush();
      test_frame_done();
      test_reset_mid_burst();
      test_stats();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
